// File: rtl/lc_pkg.sv
// Shared widths and the load-queue entry type for the lc writeback slice.
package lc_pkg;

   localparam int unsigned REG_WIDTH      = 16;
   localparam int unsigned NUM_REGS_WIDTH = 3;

   typedef struct packed {
      logic                      valid;
      logic [NUM_REGS_WIDTH-1:0] rd;
      logic                      has_data;
      logic [REG_WIDTH-1:0]      data;
   } lq_entry_t;

endpackage

// File: rtl/lc_writeback_if.sv
// Bundle of ALU, load issue/response, hazard query and register-file write signals.
interface lc_writeback_if #(
   parameter int unsigned REG_WIDTH      = lc_pkg::REG_WIDTH,
   parameter int unsigned NUM_REGS_WIDTH = lc_pkg::NUM_REGS_WIDTH
);

   logic                      alu_valid;
   logic [NUM_REGS_WIDTH-1:0] alu_rd;
   logic [REG_WIDTH-1:0]      alu_data;
   logic                      ld_issue_valid;
   logic [NUM_REGS_WIDTH-1:0] ld_issue_rd;
   logic                      ld_issue_ready;
   logic                      ld_resp_valid;
   logic [REG_WIDTH-1:0]      ld_resp_data;
   logic [NUM_REGS_WIDTH-1:0] chk_rs;
   logic [NUM_REGS_WIDTH-1:0] chk_rt;
   logic [NUM_REGS_WIDTH-1:0] chk_rd;
   logic                      rs_busy;
   logic                      rt_busy;
   logic                      rd_busy;
   logic                      write_en;
   logic [NUM_REGS_WIDTH-1:0] rd;
   logic [REG_WIDTH-1:0]      reg_in;
   logic                      ld_err;

   modport master (
      output alu_valid, alu_rd, alu_data,
      output ld_issue_valid, ld_issue_rd,
      output ld_resp_valid, ld_resp_data,
      output chk_rs, chk_rt, chk_rd,
      input  ld_issue_ready, rs_busy, rt_busy, rd_busy,
      input  write_en, rd, reg_in, ld_err
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data,
      input  ld_issue_valid, ld_issue_rd,
      input  ld_resp_valid, ld_resp_data,
      input  chk_rs, chk_rt, chk_rd,
      output ld_issue_ready, rs_busy, rt_busy, rd_busy,
      output write_en, rd, reg_in, ld_err
   );

endinterface

// File: rtl/lc_ld_queue.sv
// In-order outstanding-load queue: circular buffer with issue, response and
// head pointers, plus per-register match logic used as a hazard scoreboard.
module lc_ld_queue
   import lc_pkg::*;
#(
   parameter int unsigned LQ_DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      issue_valid,
   input  logic [NUM_REGS_WIDTH-1:0] issue_rd,
   output logic                      issue_ready,
   input  logic                      resp_store,
   input  logic                      resp_advance,
   input  logic [REG_WIDTH-1:0]      resp_data,
   input  logic                      pop,
   output lq_entry_t                 head,
   output logic                      resp_pending,
   output logic                      resp_at_head,
   input  logic [NUM_REGS_WIDTH-1:0] chk_rs,
   input  logic [NUM_REGS_WIDTH-1:0] chk_rt,
   input  logic [NUM_REGS_WIDTH-1:0] chk_rd,
   input  logic [NUM_REGS_WIDTH-1:0] chk_alu,
   output logic                      rs_match,
   output logic                      rt_match,
   output logic                      rd_match,
   output logic                      alu_match
);

   localparam int unsigned PW = $clog2(LQ_DEPTH);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] resp_ptr_q, resp_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   lq_entry_t     entry_q [LQ_DEPTH];
   lq_entry_t     entry_d [LQ_DEPTH];
   logic          issue_fire;

   // Ready looks only at registered count, so a same-cycle retire never frees a slot.
   assign issue_ready  = (count_q != (PW+1)'(LQ_DEPTH));
   assign issue_fire   = issue_valid & issue_ready;
   assign head         = entry_q[rd_ptr_q];
   // Entries fill in order, so the resp_ptr entry lacks data iff any entry does.
   assign resp_pending = entry_q[resp_ptr_q].valid & ~entry_q[resp_ptr_q].has_data;
   assign resp_at_head = (resp_ptr_q == rd_ptr_q);

   // Next-state for entries, pointers and occupancy.
   always_comb begin
      entry_d = entry_q;
      if (issue_fire) begin
         entry_d[wr_ptr_q].valid    = 1'b1;
         entry_d[wr_ptr_q].rd       = issue_rd;
         entry_d[wr_ptr_q].has_data = 1'b0;
         entry_d[wr_ptr_q].data     = '0;
      end
      if (resp_store) begin
         entry_d[resp_ptr_q].has_data = 1'b1;
         entry_d[resp_ptr_q].data     = resp_data;
      end
      if (pop) begin
         entry_d[rd_ptr_q] = '0;
      end
      wr_ptr_d   = wr_ptr_q + PW'(issue_fire);
      resp_ptr_d = resp_ptr_q + PW'(resp_advance);
      rd_ptr_d   = rd_ptr_q + PW'(pop);
      count_d    = count_q;
      case ({issue_fire, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Any valid entry targeting each queried register.
   always_comb begin
      rs_match  = 1'b0;
      rt_match  = 1'b0;
      rd_match  = 1'b0;
      alu_match = 1'b0;
      for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
         if (entry_q[i].valid) begin
            if (entry_q[i].rd == chk_rs)  rs_match  = 1'b1;
            if (entry_q[i].rd == chk_rt)  rt_match  = 1'b1;
            if (entry_q[i].rd == chk_rd)  rd_match  = 1'b1;
            if (entry_q[i].rd == chk_alu) alu_match = 1'b1;
         end
      end
   end

   // Queue state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         resp_ptr_q <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
            entry_q[i] <= '0;
         end
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         resp_ptr_q <= resp_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         entry_q    <= entry_d;
      end
   end

endmodule

// File: rtl/lc_writeback.sv
// Writeback stage: merges ALU results and in-order load returns into one
// registered register-file write, and reports hazards against pending loads.
// Optional feature macro: LC_WB_BYPASS_EN (response straight to output when
// it targets the queue head and no ALU write competes).
module lc_writeback #(
   parameter int unsigned REG_WIDTH      = lc_pkg::REG_WIDTH,
   parameter int unsigned NUM_REGS_WIDTH = lc_pkg::NUM_REGS_WIDTH,
   parameter int unsigned LQ_DEPTH       = 4
) (
   input  logic           clk,
   input  logic           rst,
   lc_writeback_if.slave  bus
);

`ifdef LC_WB_BYPASS_EN
   localparam bit BYPASS_EN = 1'b1;
`else
   localparam bit BYPASS_EN = 1'b0;
`endif

   lc_pkg::lq_entry_t         head;
   logic                      resp_pending, resp_at_head;
   logic                      rs_match, rt_match, rd_match, alu_match;
   logic                      resp_fire, bypass, retire, pop, resp_store;
   logic                      write_en_q, write_en_d;
   logic [NUM_REGS_WIDTH-1:0] rd_q, rd_d;
   logic [REG_WIDTH-1:0]      reg_in_q, reg_in_d;
   logic                      ld_err_q, ld_err_d;

   lc_ld_queue #(
      .LQ_DEPTH (LQ_DEPTH)
   ) u_ld_queue (
      .clk          (clk),
      .rst          (rst),
      .issue_valid  (bus.ld_issue_valid),
      .issue_rd     (bus.ld_issue_rd),
      .issue_ready  (bus.ld_issue_ready),
      .resp_store   (resp_store),
      .resp_advance (resp_fire),
      .resp_data    (bus.ld_resp_data),
      .pop          (pop),
      .head         (head),
      .resp_pending (resp_pending),
      .resp_at_head (resp_at_head),
      .chk_rs       (bus.chk_rs),
      .chk_rt       (bus.chk_rt),
      .chk_rd       (bus.chk_rd),
      .chk_alu      (bus.alu_rd),
      .rs_match     (rs_match),
      .rt_match     (rt_match),
      .rd_match     (rd_match),
      .alu_match    (alu_match)
   );

   // Retire priority: ALU, then bypassed response, then stored head data.
   always_comb begin
      resp_fire  = bus.ld_resp_valid & resp_pending;
      bypass     = BYPASS_EN & resp_fire & resp_at_head & ~bus.alu_valid;
      retire     = ~bus.alu_valid & head.valid & head.has_data;
      pop        = retire | bypass;
      resp_store = resp_fire & ~bypass;
      write_en_d = 1'b0;
      rd_d       = rd_q;
      reg_in_d   = reg_in_q;
      if (bus.alu_valid) begin
         write_en_d = 1'b1;
         rd_d       = bus.alu_rd;
         reg_in_d   = bus.alu_data;
      end else if (bypass) begin
         write_en_d = 1'b1;
         rd_d       = head.rd;
         reg_in_d   = bus.ld_resp_data;
      end else if (retire) begin
         write_en_d = 1'b1;
         rd_d       = head.rd;
         reg_in_d   = head.data;
      end
      ld_err_d = ld_err_q
               | (bus.ld_resp_valid & ~resp_pending)
               | (bus.alu_valid & alu_match);
   end

   // Output register and sticky error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         write_en_q <= 1'b0;
         rd_q       <= '0;
         reg_in_q   <= '0;
         ld_err_q   <= 1'b0;
      end else begin
         write_en_q <= write_en_d;
         rd_q       <= rd_d;
         reg_in_q   <= reg_in_d;
         ld_err_q   <= ld_err_d;
      end
   end

   assign bus.write_en = write_en_q;
   assign bus.rd       = rd_q;
   assign bus.reg_in   = reg_in_q;
   assign bus.ld_err   = ld_err_q;
   assign bus.rs_busy  = rs_match | (write_en_q & (rd_q == bus.chk_rs));
   assign bus.rt_busy  = rt_match | (write_en_q & (rd_q == bus.chk_rt));
   assign bus.rd_busy  = rd_match | (write_en_q & (rd_q == bus.chk_rd));

endmodule

// File: tb/tb_lc_writeback.sv
// Self-checking bench for lc_writeback; honours LC_WB_BYPASS_EN when defined.
module tb_lc_writeback;

`ifdef LC_WB_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   logic [18:0] sb [$];      // expected writes {rd, data} in order
   logic [2:0]  pending [$]; // issued load rds still awaiting data

   lc_writeback_if #(.REG_WIDTH(16), .NUM_REGS_WIDTH(3)) bus ();

   lc_writeback #(.REG_WIDTH(16), .NUM_REGS_WIDTH(3), .LQ_DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Every register-file write must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!rst && bus.write_en) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL wb_unexpected: got rd=%0d data=%h, required no write", bus.rd, bus.reg_in);
         end else begin
            logic [18:0] exp;
            exp = sb.pop_front();
            if ({bus.rd, bus.reg_in} !== exp) begin
               errors++;
               $display("FAIL wb_data: got rd=%0d data=%h, required rd=%0d data=%h",
                        bus.rd, bus.reg_in, exp[18:16], exp[15:0]);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
      bus.ld_issue_valid = 0; bus.ld_issue_rd = 0;
      bus.ld_resp_valid = 0; bus.ld_resp_data = 0;
      bus.chk_rs = 0; bus.chk_rt = 0; bus.chk_rd = 0;
   endtask

   task automatic do_reset();
      rst = 1;
      sb.delete();
      pending.delete();
      step();
      rst = 0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: got %0d writes outstanding, required 0", sb.size());
      end
      step();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1;
      step();
      step();
      rst = 0;
      checks++;
      if ({bus.write_en, bus.rd, bus.reg_in, bus.ld_err} !== 21'd0) begin
         errors++;
         $display("FAIL reset_outputs: got we=%b rd=%0d data=%h err=%b, required all 0",
                  bus.write_en, bus.rd, bus.reg_in, bus.ld_err);
      end
      checks++;
      if ({bus.ld_issue_ready, bus.rs_busy, bus.rt_busy, bus.rd_busy} !== 4'b1000) begin
         errors++;
         $display("FAIL reset_flags: got ready/busy=%b, required 1000",
                  {bus.ld_issue_ready, bus.rs_busy, bus.rt_busy, bus.rd_busy});
      end
   endtask

   task automatic test_alu();
      bus.alu_valid = 1; bus.alu_rd = 3'd5; bus.alu_data = 16'h1234;
      sb.push_back({3'd5, 16'h1234});
      step();
      bus.alu_valid = 0;
      checks++;
      if ({bus.write_en, bus.rd, bus.reg_in} !== {1'b1, 3'd5, 16'h1234}) begin
         errors++;
         $display("FAIL alu_write: got we=%b rd=%0d data=%h, required we=1 rd=5 data=1234",
                  bus.write_en, bus.rd, bus.reg_in);
      end
      step();
      checks++;
      if (bus.write_en !== 1'b0) begin
         errors++;
         $display("FAIL alu_idle: got we=%b, required 0", bus.write_en);
      end
   endtask

   task automatic test_load_latency();
      bus.chk_rt = 3'd3;
      bus.ld_issue_valid = 1; bus.ld_issue_rd = 3'd3;
      pending.push_back(3'd3);
      step();
      bus.ld_issue_valid = 0;
      checks++;
      if (bus.rt_busy !== 1'b1) begin
         errors++;
         $display("FAIL ld_busy_rise: got rt_busy=%b, required 1", bus.rt_busy);
      end
      step();
      step();
      checks++;
      if (bus.rt_busy !== 1'b1 || bus.write_en !== 1'b0) begin
         errors++;
         $display("FAIL ld_wait: got rt_busy=%b we=%b, required 1 0", bus.rt_busy, bus.write_en);
      end
      bus.ld_resp_valid = 1; bus.ld_resp_data = 16'hBEEF;
      sb.push_back({pending.pop_front(), 16'hBEEF});
      step();
      bus.ld_resp_valid = 0;
      for (int k = 1; k <= 3; k++) begin
         checks++;
         if (bus.write_en !== (k == LAT) || bus.rt_busy !== (k <= LAT)) begin
            errors++;
            $display("FAIL ld_latency: cycle +%0d got we=%b rt_busy=%b, required we=%b rt_busy=%b",
                     k, bus.write_en, bus.rt_busy, (k == LAT), (k <= LAT));
         end
         step();
      end
   endtask

   task automatic test_fill();
      bus.chk_rd = 3'd7;
      bus.chk_rs = 3'd1;
      for (int i = 0; i < 4; i++) begin
         bus.ld_issue_valid = 1; bus.ld_issue_rd = 3'(i + 1);
         pending.push_back(3'(i + 1));
         step();
         checks++;
         if (bus.ld_issue_ready !== (i < 3)) begin
            errors++;
            $display("FAIL fill_ready: after issue %0d got ready=%b, required %b",
                     i + 1, bus.ld_issue_ready, (i < 3));
         end
      end
      bus.ld_issue_rd = 3'd7;
      step();
      bus.ld_issue_valid = 0;
      checks++;
      if (bus.ld_issue_ready !== 1'b0 || bus.rd_busy !== 1'b0 || bus.rs_busy !== 1'b1) begin
         errors++;
         $display("FAIL fill_ignore: got ready=%b rd_busy=%b rs_busy=%b, required 0 0 1",
                  bus.ld_issue_ready, bus.rd_busy, bus.rs_busy);
      end
      for (int i = 0; i < 4; i++) begin
         bus.ld_resp_valid = 1; bus.ld_resp_data = 16'hA001 + 16'(i);
         sb.push_back({pending.pop_front(), 16'hA001 + 16'(i)});
         step();
      end
      bus.ld_resp_valid = 0;
      drain();
      step();
      checks++;
      if (bus.ld_issue_ready !== 1'b1 || bus.rs_busy !== 1'b0) begin
         errors++;
         $display("FAIL fill_empty: got ready=%b rs_busy=%b, required 1 0", bus.ld_issue_ready, bus.rs_busy);
      end
   endtask

   task automatic test_collision();
      bus.ld_issue_valid = 1; bus.ld_issue_rd = 3'd2;
      pending.push_back(3'd2);
      step();
      bus.ld_issue_valid = 0;
      step();
      bus.alu_valid = 1; bus.alu_rd = 3'd6; bus.alu_data = 16'h0606;
      bus.ld_resp_valid = 1; bus.ld_resp_data = 16'hC0DE;
      sb.push_back({3'd6, 16'h0606});
      sb.push_back({pending.pop_front(), 16'hC0DE});
      step();
      bus.alu_valid = 0; bus.ld_resp_valid = 0;
      checks++;
      if ({bus.write_en, bus.rd, bus.reg_in} !== {1'b1, 3'd6, 16'h0606}) begin
         errors++;
         $display("FAIL coll_alu: got we=%b rd=%0d data=%h, required we=1 rd=6 data=0606",
                  bus.write_en, bus.rd, bus.reg_in);
      end
      step();
      checks++;
      if ({bus.write_en, bus.rd, bus.reg_in} !== {1'b1, 3'd2, 16'hC0DE}) begin
         errors++;
         $display("FAIL coll_load: got we=%b rd=%0d data=%h, required we=1 rd=2 data=c0de",
                  bus.write_en, bus.rd, bus.reg_in);
      end
      drain();
   endtask

   task automatic test_errors();
      checks++;
      if (bus.ld_err !== 1'b0) begin
         errors++;
         $display("FAIL err_clean: got ld_err=%b, required 0", bus.ld_err);
      end
      bus.ld_resp_valid = 1; bus.ld_resp_data = 16'hDEAD;
      step();
      bus.ld_resp_valid = 0;
      checks++;
      if (bus.ld_err !== 1'b1) begin
         errors++;
         $display("FAIL err_empty_resp: got ld_err=%b, required 1", bus.ld_err);
      end
      step();
      step();
      checks++;
      if (bus.ld_err !== 1'b1 || bus.write_en !== 1'b0) begin
         errors++;
         $display("FAIL err_sticky: got ld_err=%b we=%b, required 1 0", bus.ld_err, bus.write_en);
      end
      do_reset();
      checks++;
      if (bus.ld_err !== 1'b0) begin
         errors++;
         $display("FAIL err_rst_clear: got ld_err=%b, required 0", bus.ld_err);
      end
      bus.ld_issue_valid = 1; bus.ld_issue_rd = 3'd4;
      pending.push_back(3'd4);
      step();
      bus.ld_issue_valid = 0;
      bus.alu_valid = 1; bus.alu_rd = 3'd4; bus.alu_data = 16'h4444;
      sb.push_back({3'd4, 16'h4444});
      step();
      bus.alu_valid = 0;
      checks++;
      if (bus.ld_err !== 1'b1 || {bus.write_en, bus.rd, bus.reg_in} !== {1'b1, 3'd4, 16'h4444}) begin
         errors++;
         $display("FAIL err_alu_match: got ld_err=%b we=%b rd=%0d data=%h, required 1 1 4 4444",
                  bus.ld_err, bus.write_en, bus.rd, bus.reg_in);
      end
      bus.ld_resp_valid = 1; bus.ld_resp_data = 16'h0440;
      sb.push_back({pending.pop_front(), 16'h0440});
      step();
      bus.ld_resp_valid = 0;
      drain();
      do_reset();
   endtask

   task automatic test_reset_mid();
      bus.chk_rs = 3'd1; bus.chk_rt = 3'd2; bus.chk_rd = 3'd1;
      for (int i = 1; i <= 2; i++) begin
         bus.ld_issue_valid = 1; bus.ld_issue_rd = 3'(i);
         pending.push_back(3'(i));
         step();
      end
      bus.ld_issue_valid = 0;
      checks++;
      if ({bus.rs_busy, bus.rt_busy} !== 2'b11) begin
         errors++;
         $display("FAIL mid_busy: got rs/rt_busy=%b, required 11", {bus.rs_busy, bus.rt_busy});
      end
      do_reset();
      checks++;
      if ({bus.write_en, bus.rs_busy, bus.rt_busy, bus.rd_busy, bus.ld_issue_ready} !== 5'b00001) begin
         errors++;
         $display("FAIL mid_reset: got we/rs/rt/rd_busy/ready=%b, required 00001",
                  {bus.write_en, bus.rs_busy, bus.rt_busy, bus.rd_busy, bus.ld_issue_ready});
      end
      step();
      step();
      checks++;
      if (bus.write_en !== 1'b0 || bus.rs_busy !== 1'b0) begin
         errors++;
         $display("FAIL mid_quiet: got we=%b rs_busy=%b, required 0 0", bus.write_en, bus.rs_busy);
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load_latency();
      test_fill();
      test_collision();
      test_errors();
      test_reset_mid();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: got %0d expected writes unseen, required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
